// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and the data stage: arbitration,
// req/ack handshake with timeout, byte/word lane formatting and pipeline stall.
module mem_port_sequencer #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [31:0]   if_rdata_o,
    output logic          if_done_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic          d_byte_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    output logic [31:0]   d_rdata_o,
    output logic          d_done_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          err_misalign_o,
    output logic          err_timeout_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q;
    logic            last_grant_q;   // 0 = IF, 1 = D
    logic            gnt_d_q;
    logic            we_q;
    logic            byte_q;
    logic [1:0]      lane_q;
    logic [TW-1:0]   timer_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [3:0]      mem_be_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            if_done_q;
    logic            d_done_q;
    logic            err_mis_q;
    logic            err_to_q;

    logic            pick_d_s;
    logic            misalign_s;
    logic            store_s;
    logic [AW-1:0]   sel_addr_s;

    function automatic logic [31:0] lane_sext(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    // Arbitration: a lone request wins; with both pending, the side not granted last wins.
    always_comb begin
        pick_d_s = d_req_i & (~if_req_i | ~last_grant_q);
        store_s  = pick_d_s & d_we_i;
        if (pick_d_s) begin
            sel_addr_s = d_addr_i;
            misalign_s = ~d_byte_i & (d_addr_i[1:0] != 2'b00);
        end else begin
            sel_addr_s = if_addr_i;
            misalign_s = (if_addr_i[1:0] != 2'b00);
        end
    end

    assign stall_o = (if_req_i & ~if_done_q) | (d_req_i & ~d_done_q);

    // Sequencer FSM with all memory-side and completion outputs registered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b0;
            gnt_d_q      <= 1'b0;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 2'b00;
            timer_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req_i | d_req_i) begin
                        last_grant_q <= pick_d_s;
                        gnt_d_q      <= pick_d_s;
                        we_q         <= store_s;
                        byte_q       <= pick_d_s & d_byte_i;
                        lane_q       <= sel_addr_s[1:0];
                        timer_q      <= '0;
                        if (misalign_s) begin
                            state_q   <= S_DONE;
                            if_done_q <= ~pick_d_s;
                            d_done_q  <= pick_d_s;
                            err_mis_q <= 1'b1;
                        end else begin
                            state_q    <= S_ACCESS;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= store_s;
                            mem_addr_q <= {sel_addr_s[AW-1:2], 2'b00};
                            mem_be_q   <= (store_s & d_byte_i) ? (4'b0001 << sel_addr_s[1:0]) : 4'b1111;
                            if (store_s) begin
                                mem_wdata_q <= d_byte_i ? {4{d_wdata_i[7:0]}} : d_wdata_i;
                            end else begin
                                mem_wdata_q <= 32'h0;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack_i || (timer_q == TW'(TIMEOUT - 1))) begin
                        state_q     <= S_DONE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b0000;
                        mem_wdata_q <= 32'h0;
                        if_done_q   <= ~gnt_d_q;
                        d_done_q    <= gnt_d_q;
                        err_to_q    <= ~mem_ack_i;
                        // Stores return nothing; a timeout leaves the held read data untouched.
                        if (mem_ack_i && gnt_d_q && !we_q) begin
                            d_rdata_q <= byte_q ? lane_sext(mem_rdata_i, lane_q) : mem_rdata_i;
                        end else if (mem_ack_i && !gnt_d_q) begin
                            if_rdata_q <= mem_rdata_i;
                        end else begin
                            d_rdata_q <= d_rdata_q;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o     = if_rdata_q;
    assign if_done_o      = if_done_q;
    assign d_rdata_o      = d_rdata_q;
    assign d_done_o       = d_done_q;
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_be_o       = mem_be_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign err_misalign_o = err_mis_q;
    assign err_timeout_o  = err_to_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed scenarios then random traffic, checked against a
// byte-addressed memory model and an alternating-priority arbitration model.
module tb_mem_port_sequencer;

    localparam int AW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req, d_req, d_we, d_byte, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata, mem_rdata;
    logic [31:0]   if_rdata_o, d_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;
    logic          if_done_o, d_done_o, stall_o, mem_req_o, mem_we_o;
    logic          err_misalign_o, err_timeout_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bmem [256];
    logic [31:0] phys [64];
    logic        last_m;
    logic [31:0] exp_if, exp_d;

    always #5 clk = ~clk;

    mem_port_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_byte_i(d_byte), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_d();
        return d_req && (!if_req || !last_m);
    endfunction

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {bmem[b + 8'd3], bmem[b + 8'd2], bmem[b + 8'd1], bmem[b]};
    endfunction

    task automatic set_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic set_d(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_byte  = bt;
        d_addr  = a;
        d_wdata = wd;
    endtask

    // Waits for the expected requester's completion, acting as the memory on the way.
    // ack_dly < 0 means the memory never answers.
    task automatic serve(input logic is_d, input int ack_dly, input logic [1:0] drop, output int k_done);
        logic [31:0] a, e_wd;
        logic [7:0]  a8, b4;
        logic [3:0]  e_be;
        logic        mis, st, got;
        int          nreq, k_ack, sx, exp_n;
        a     = is_d ? d_addr : if_addr;
        a8    = a[7:0];
        b4    = {a8[7:2], 2'b00};
        mis   = is_d ? (!d_byte && a[1:0] != 2'b00) : (a[1:0] != 2'b00);
        st    = is_d && d_we;
        e_be  = (st && d_byte) ? (4'b0001 << a[1:0]) : 4'b1111;
        e_wd  = d_byte ? {4{d_wdata[7:0]}} : d_wdata;
        nreq  = 0;
        k_ack = -1;
        got   = 1'b0;
        k_done = -1;
        for (int k = 0; k < TIMEOUT + 8 && !got; k++) begin
            @(negedge clk);
            if (if_done_o || d_done_o) begin
                got    = 1'b1;
                k_done = k;
            end else if (mem_req_o) begin
                if (nreq == 0) begin
                    chk("mem_addr", mem_addr_o, {a[31:2], 2'b00});
                    chk("mem_we", 32'(mem_we_o), 32'(st));
                    chk("mem_be", 32'(mem_be_o), 32'(e_be));
                    if (st) chk("mem_wdata", mem_wdata_o, e_wd);
                end
                if (nreq == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = phys[a[7:2]];
                    for (int i = 0; i < 4; i++)
                        if (mem_we_o && mem_be_o[i]) phys[a[7:2]][8*i +: 8] = mem_wdata_o[8*i +: 8];
                    k_ack = k;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                nreq++;
                chk("stall_busy", 32'(stall_o), 32'd1);
            end
        end
        mem_ack = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("d_done", 32'(d_done_o), 32'(is_d));
            chk("if_done", 32'(if_done_o), 32'(!is_d));
            chk("err_misalign", 32'(err_misalign_o), 32'(mis));
            chk("err_timeout", 32'(err_timeout_o), 32'(!mis && ack_dly < 0));
            exp_n = mis ? 0 : (ack_dly < 0 ? TIMEOUT : ack_dly + 1);
            chk("mem_req_cycles", 32'(nreq), 32'(exp_n));
            if (!mis && ack_dly >= 0) begin
                chk("ack_to_done", 32'(k_done - k_ack), 32'd1);
                if (st && d_byte) begin
                    bmem[a8] = d_wdata[7:0];
                end else if (st) begin
                    for (int i = 0; i < 4; i++) bmem[b4 + 8'(i)] = d_wdata[8*i +: 8];
                end else if (is_d && d_byte) begin
                    sx    = $signed(bmem[a8]);
                    exp_d = 32'(sx);
                end else if (is_d) begin
                    exp_d = model_word(a8);
                end else begin
                    exp_if = model_word(a8);
                end
            end
            last_m = is_d;
            chk("if_rdata", if_rdata_o, exp_if);
            chk("d_rdata", d_rdata_o, exp_d);
            chk("mem_req_off", 32'(mem_req_o), 32'd0);
            chk("stall_at_done", 32'(stall_o), 32'(is_d ? if_req : d_req));
        end
        @(posedge clk);
        #1;
        if (drop[0]) if_req = 1'b0;
        if (drop[1]) d_req = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(if_done_o | d_done_o), 32'd0);
    endtask

    task automatic rand_addr(input logic allow_mis, output logic [31:0] a);
        a = $urandom;
        if (!allow_mis || $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
    endtask

    initial begin
        int          k;
        logic        w, got, bt;
        logic [31:0] ra, rw;
        int          dly, dly2, mode;

        reset_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        last_m = 1'b0; exp_if = 32'h0; exp_d = 32'h0;
        for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)
            phys[i] = {bmem[8'(4*i+3)], bmem[8'(4*i+2)], bmem[8'(4*i+1)], bmem[8'(4*i)]};

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_dones", 32'({if_done_o, d_done_o}), 32'd0);
        chk("rst_errs", 32'({err_misalign_o, err_timeout_o}), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        chk("rst_mem_be", 32'(mem_be_o), 32'd0);
        reset_n = 1'b1;

        // Reset while an access is outstanding.
        set_if(32'h40);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_req_o) got = 1'b1;
        end
        chk("reach_access", 32'(got), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req_o), 32'd0);
        chk("abort_dones", 32'({if_done_o, d_done_o}), 32'd0);
        chk("abort_errs", 32'({err_misalign_o, err_timeout_o}), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_after_rst", 32'({mem_req_o, if_done_o, d_done_o}), 32'd0);
        end
        mem_ack = 1'b0;

        // Plain fetch.
        set_if(32'h40);
        serve(1'b0, 2, 2'b11, k);

        // Simultaneous requests, then both held for strict alternation.
        set_if(32'h80);
        set_d(1'b0, 1'b0, 32'h84, 32'h0);
        w = pick_d();
        chk("first_grant_d", 32'(w), 32'd1);
        serve(w, 1, w ? 2'b10 : 2'b01, k);
        serve(pick_d(), 1, 2'b11, k);
        set_if(32'h88);
        set_d(1'b0, 1'b0, 32'h8C, 32'h0);
        repeat (4) serve(pick_d(), 0, 2'b00, k);
        serve(pick_d(), 0, 2'b11, k);

        // Byte lanes.
        set_d(1'b1, 1'b1, 32'h103, 32'h000000A5);
        serve(1'b1, 1, 2'b11, k);
        set_d(1'b1, 1'b0, 32'h100, 32'h00800000);
        serve(1'b1, 0, 2'b11, k);
        set_d(1'b0, 1'b1, 32'h102, 32'h0);
        serve(1'b1, 1, 2'b11, k);
        chk("byte_load_sext", d_rdata_o, 32'hFFFFFF80);

        // Misaligned word load.
        set_d(1'b0, 1'b0, 32'h102, 32'h0);
        serve(1'b1, 0, 2'b11, k);
        chk("mis_latency", 32'(k), 32'd0);

        // No ack: timeout, then a normal fetch.
        set_if(32'h10);
        serve(1'b0, -1, 2'b11, k);
        set_if(32'h14);
        serve(1'b0, 1, 2'b11, k);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            dly  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
            dly2 = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
            if (mode != 1) begin
                rand_addr(1'b1, ra);
                set_if(ra);
            end
            if (mode != 0) begin
                bt = 1'($urandom_range(0, 1));
                rand_addr(1'b1, ra);
                if (bt) ra[1:0] = 2'($urandom_range(0, 3));
                rw = $urandom;
                set_d(1'($urandom_range(0, 1)), bt, ra, rw);
            end
            if (mode == 2) begin
                w = pick_d();
                serve(w, dly, w ? 2'b10 : 2'b01, k);
                serve(pick_d(), dly2, 2'b11, k);
            end else begin
                serve(mode == 1, dly, 2'b11, k);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
